// File: rtl/rs_encoder_stream_if.sv
// Streaming codeword bus between a symbol source and the RS encoder.
// The slave side is the encoder; the master side drives message symbols.
interface rs_encoder_stream_if #(
  parameter int word_length = 8
);
  logic                   i_start_codeword;
  logic                   i_end_codeword;
  logic                   i_valid;
  logic [word_length-1:0] i_symbol;
  logic                   o_start_codeword;
  logic                   o_end_codeword;
  logic                   o_error;
  logic                   o_in_ready;
  logic                   o_valid;
  logic [word_length-1:0] o_symbol;

  modport slave (
    input  i_start_codeword, i_end_codeword, i_valid, i_symbol,
    output o_start_codeword, o_end_codeword, o_error, o_in_ready, o_valid, o_symbol
  );

  modport master (
    output i_start_codeword, i_end_codeword, i_valid, i_symbol,
    input  o_start_codeword, o_end_codeword, o_error, o_in_ready, o_valid, o_symbol
  );
endinterface

// File: rtl/rs_encoder_stream.sv
// Systematic streaming Reed-Solomon encoder over GF(2^word_length).
// Message symbols are echoed with one cycle of latency while an LFSR
// divides by the generator polynomial; the n-k remainder symbols are then
// shifted out as parity while the input is held off.
module rs_encoder_stream #(
  parameter int word_length = 8,
  parameter int n           = 15,
  parameter int k           = 11
) (
  input  logic                clk,
  input  logic                rst,
  rs_encoder_stream_if.slave  bus
);

  localparam int NK   = n - k;
  localparam int CW   = $clog2(n + 1);
  localparam int PRIM = 'h11D;

  typedef logic [word_length-1:0] sym_t;
  typedef enum logic [1:0] {S_IDLE, S_MSG, S_PARITY} state_t;

  // GF(2^m) multiply: shift-and-add with reduction by the primitive polynomial.
  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < word_length; i++) begin
      if (b[i]) acc = acc ^ aa;
      if (aa[word_length-1]) aa = (aa << 1) ^ sym_t'(PRIM);
      else                   aa = aa << 1;
    end
    return acc;
  endfunction

  // Non-monic coefficients g[0..NK-1] of prod (x + alpha^i), alpha = 2.
  function automatic logic [NK*word_length-1:0] gen_poly();
    sym_t c [NK+1];
    sym_t root;
    logic [NK*word_length-1:0] res;
    for (int j = 0; j <= NK; j++) c[j] = '0;
    c[0] = sym_t'(1);
    root = sym_t'(1);
    for (int i = 0; i < NK; i++) begin
      for (int j = NK; j >= 1; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
      c[0] = gf_mul(c[0], root);
      root = gf_mul(root, sym_t'(2));
    end
    for (int j = 0; j < NK; j++) res[j*word_length +: word_length] = c[j];
    return res;
  endfunction

  localparam logic [NK*word_length-1:0] G_PACK = gen_poly();

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  sym_t           p_q [NK];
  sym_t           p_d [NK];
  logic           o_valid_q, o_valid_d;
  logic           o_start_q, o_start_d;
  logic           o_end_q, o_end_d;
  logic           o_err_q, o_err_d;
  logic           in_ready_q, in_ready_d;
  sym_t           o_sym_q, o_sym_d;

  sym_t           s_in;
  sym_t           fb;
  sym_t           seed [NK];
  sym_t           upd [NK];

  assign s_in = bus.i_symbol;

  // Candidate LFSR contents: fresh seed for a first symbol, or a normal division step.
  always_comb begin
    fb = s_in ^ p_q[NK-1];
    for (int j = 0; j < NK; j++) begin
      seed[j] = gf_mul(s_in, G_PACK[j*word_length +: word_length]);
    end
    upd[0] = gf_mul(fb, G_PACK[0 +: word_length]);
    for (int j = 1; j < NK; j++) begin
      upd[j] = p_q[j-1] ^ gf_mul(fb, G_PACK[j*word_length +: word_length]);
    end
  end

  // Framing FSM: next state, counter, LFSR and next registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    o_valid_d = 1'b0;
    o_start_d = 1'b0;
    o_end_d   = 1'b0;
    o_err_d   = 1'b0;
    o_sym_d   = o_sym_q;

    case (state_q)
      S_IDLE, S_MSG: begin
        if (bus.i_valid) begin
          if (bus.i_start_codeword) begin
            // A start always opens a new frame; inside MSG it is also a framing error.
            o_valid_d = 1'b1;
            o_start_d = 1'b1;
            o_sym_d   = s_in;
            o_err_d   = (state_q == S_MSG);
            if (bus.i_end_codeword) begin
              o_end_d = 1'b1;
              o_err_d = 1'b1;
              for (int j = 0; j < NK; j++) p_d[j] = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              p_d     = seed;
              cnt_d   = CW'(1);
              state_d = S_MSG;
            end
          end else if (state_q == S_IDLE) begin
            o_err_d = 1'b1;
          end else begin
            o_valid_d = 1'b1;
            o_sym_d   = s_in;
            if (cnt_q == CW'(k - 1)) begin
              // k-th symbol closes the message whether or not end was flagged.
              p_d     = upd;
              cnt_d   = '0;
              o_err_d = ~bus.i_end_codeword;
              state_d = S_PARITY;
            end else if (bus.i_end_codeword) begin
              o_end_d = 1'b1;
              o_err_d = 1'b1;
              for (int j = 0; j < NK; j++) p_d[j] = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end else begin
              p_d   = upd;
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      S_PARITY: begin
        o_valid_d = 1'b1;
        o_sym_d   = p_q[NK-1];
        for (int j = NK - 1; j >= 1; j--) p_d[j] = p_q[j-1];
        p_d[0] = '0;
        if (cnt_q == CW'(NK - 1)) begin
          o_end_d = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    in_ready_d = (state_d != S_PARITY);
  end

  // State, LFSR and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      for (int j = 0; j < NK; j++) p_q[j] <= '0;
      o_valid_q  <= 1'b0;
      o_start_q  <= 1'b0;
      o_end_q    <= 1'b0;
      o_err_q    <= 1'b0;
      in_ready_q <= 1'b1;
      o_sym_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      for (int j = 0; j < NK; j++) p_q[j] <= p_d[j];
      o_valid_q  <= o_valid_d;
      o_start_q  <= o_start_d;
      o_end_q    <= o_end_d;
      o_err_q    <= o_err_d;
      in_ready_q <= in_ready_d;
      o_sym_q    <= o_sym_d;
    end
  end

  assign bus.o_valid          = o_valid_q;
  assign bus.o_start_codeword = o_start_q;
  assign bus.o_end_codeword   = o_end_q;
  assign bus.o_error          = o_err_q;
  assign bus.o_in_ready       = in_ready_q;
  assign bus.o_symbol         = o_sym_q;

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Testbench for rs_encoder_stream: directed and random frames, scoreboard
// fed by a message-level model that computes parity by polynomial division.
module tb_rs_encoder_stream;
  localparam int W  = 8;
  localparam int N  = 15;
  localparam int K  = 11;
  localparam int NK = N - K;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_encoder_stream_if #(.word_length(W)) bus();

  rs_encoder_stream #(.word_length(W), .n(N), .k(K)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit vld;
    bit st;
    bit en;
    bit er;
    int sym;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   gexp [0:254];
  int   glog [0:255];
  int   gpoly [0:NK];
  int   out_log[$];
  int   run_len = 0;
  int   max_run = 0;
  int   blocked = 0;
  bit   frame_open = 0;
  int   msg[$];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic push_exp(input bit v, input bit st, input bit en, input bit er, input int s);
    exp_t e;
    e.vld = v; e.st = st; e.en = en; e.er = er; e.sym = s;
    sb.push_back(e);
  endtask

  // Remainder of m(x)*x^NK divided by monic g(x), by long division.
  task automatic push_parity();
    int c [N];
    int coef;
    for (int i = 0; i < N; i++) c[i] = (i < K) ? msg[i] : 0;
    for (int i = 0; i < K; i++) begin
      coef = c[i];
      if (coef != 0)
        for (int j = 0; j <= NK; j++) c[i+j] = c[i+j] ^ gmul(coef, gpoly[NK-j]);
    end
    for (int i = K; i < N; i++) push_exp(1, 0, (i == N - 1), 0, c[i]);
  endtask

  task automatic model_accept(input bit st, input bit en, input int s);
    if (st) begin
      push_exp(1, 1, en, en | frame_open, s);
      msg.delete();
      if (en) frame_open = 0;
      else begin
        frame_open = 1;
        msg.push_back(s);
      end
    end else if (frame_open) begin
      msg.push_back(s);
      if (msg.size() == K) begin
        push_exp(1, 0, 0, !en, s);
        push_parity();
        frame_open = 0;
        blocked = NK;
      end else if (en) begin
        push_exp(1, 0, 1, 1, s);
        frame_open = 0;
      end else begin
        push_exp(1, 0, 0, 0, s);
      end
    end else begin
      push_exp(0, 0, 0, 1, 0);
    end
  endtask

  task automatic cycle(input bit v, input bit st, input bit en, input int s, output bit acc);
    bus.i_valid          = v;
    bus.i_start_codeword = st;
    bus.i_end_codeword   = en;
    bus.i_symbol         = s[7:0];
    chk("in_ready", bus.o_in_ready, (blocked == 0));
    acc = v && (blocked == 0);
    if (acc) model_accept(st, en, s);
    else if (blocked > 0) blocked--;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int nc);
    bit acc;
    for (int i = 0; i < nc; i++) cycle(0, 0, 0, 0, acc);
  endtask

  task automatic send(input bit st, input bit en, input int s);
    bit acc;
    int tries;
    tries = 0;
    do begin
      cycle(1, st, en, s, acc);
      tries++;
    end while (!acc && tries < NK + 3);
    if (!acc) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout: symbol %0h never accepted, expected acceptance", s);
    end
  endtask

  task automatic zero_frame();
    for (int i = 0; i < K; i++) send(i == 0, i == K - 1, 0);
  endtask

  task automatic maybe_gap();
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
  endtask

  task automatic rand_frame();
    int kind;
    int len;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      len = $urandom_range(1, K - 1);
      for (int i = 0; i < len; i++) begin
        maybe_gap();
        send(i == 0, i == len - 1, $urandom_range(0, 255));
      end
    end else if (kind == 1) begin
      for (int i = 0; i < K; i++) begin
        maybe_gap();
        send(i == 0, 0, $urandom_range(0, 255));
      end
    end else begin
      if (kind == 2) send(0, 0, $urandom_range(0, 255));
      for (int i = 0; i < K; i++) begin
        maybe_gap();
        send(i == 0, i == K - 1, $urandom_range(0, 255));
      end
    end
  endtask

  // Monitor: every presented output (valid or error pulse) is checked against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        run_len = 0;
      end else begin
        if (bus.o_valid) begin
          run_len++;
          if (run_len > max_run) max_run = run_len;
          out_log.push_back(int'(bus.o_symbol));
        end else begin
          run_len = 0;
        end
        if (bus.o_valid || bus.o_error) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_output: got vld=%0b st=%0b en=%0b er=%0b sym=%0h, expected nothing",
                     bus.o_valid, bus.o_start_codeword, bus.o_end_codeword, bus.o_error, bus.o_symbol);
          end else begin
            e = sb.pop_front();
            if (bus.o_valid != e.vld || bus.o_start_codeword != e.st || bus.o_end_codeword != e.en ||
                bus.o_error != e.er || (e.vld && int'(bus.o_symbol) != e.sym)) begin
              n_mis++;
              $display("FAIL output: got vld=%0b st=%0b en=%0b er=%0b sym=%0h, expected vld=%0b st=%0b en=%0b er=%0b sym=%0h",
                       bus.o_valid, bus.o_start_codeword, bus.o_end_codeword, bus.o_error, bus.o_symbol,
                       e.vld, e.st, e.en, e.er, e.sym);
            end
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int x;
    int unit_par [4];
    unit_par = '{'h0F, 'h36, 'h78, 'h40};

    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
    end
    glog[0] = 0;
    for (int j = 0; j <= NK; j++) gpoly[j] = 0;
    gpoly[0] = 1;
    for (int i = 0; i < NK; i++) begin
      for (int j = NK; j >= 1; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], gexp[i]);
      gpoly[0] = gmul(gpoly[0], gexp[i]);
    end

    bus.i_valid = 0; bus.i_start_codeword = 0; bus.i_end_codeword = 0; bus.i_symbol = '0;
    rst = 1;
    #12;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_symbol", bus.o_symbol, 0);
    chk("rst_start", bus.o_start_codeword, 0);
    chk("rst_end", bus.o_end_codeword, 0);
    chk("rst_error", bus.o_error, 0);
    chk("rst_ready", bus.o_in_ready, 1);
    rst = 0;
    @(posedge clk);
    #1;

    // Zero frame followed back-to-back by the unit frame.
    max_run = 0;
    zero_frame();
    for (int i = 0; i < K; i++) send(i == 0, i == K - 1, (i == K - 1) ? 1 : 0);
    idle(NK + 4);
    chk("b2b_contiguous_run", max_run, 2 * N);
    for (int i = 0; i < 4; i++)
      chk($sformatf("unit_parity%0d", i), out_log[out_log.size() - 4 + i], unit_par[i]);

    // Early end on the 6th symbol.
    for (int i = 0; i < 6; i++) send(i == 0, i == 5, $urandom_range(0, 255));
    idle(3);

    // Stray symbol in IDLE.
    send(0, 0, 'hA5);
    idle(2);

    // 11th symbol without end.
    for (int i = 0; i < K; i++) send(i == 0, 0, $urandom_range(0, 255));
    idle(NK + 2);

    // Restart mid-frame, then a one-symbol frame.
    for (int i = 0; i < 4; i++) send(i == 0, 0, $urandom_range(0, 255));
    for (int i = 0; i < K; i++) send(i == 0, i == K - 1, $urandom_range(0, 255));
    send(1, 1, 'h3C);
    idle(NK + 2);

    // Random frames with gaps and framing faults.
    for (int f = 0; f < 40; f++) rand_frame();
    idle(NK + 3);

    // Asynchronous reset during the 3rd parity symbol.
    zero_frame();
    idle(3);
    #2;
    rst = 1;
    sb.delete();
    #1;
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_symbol", bus.o_symbol, 0);
    chk("arst_start", bus.o_start_codeword, 0);
    chk("arst_end", bus.o_end_codeword, 0);
    chk("arst_error", bus.o_error, 0);
    chk("arst_ready", bus.o_in_ready, 1);
    blocked = 0;
    frame_open = 0;
    msg.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    zero_frame();
    idle(NK + 4);

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rs_encoder_stream.md
Name: rs_encoder_stream

Overview:
- Systematic Reed-Solomon encoder over GF(2^word_length). It is the transmit-side counterpart of the streaming RS decoder and uses the same codeword framing (start/end/valid/ready).
- Accepts k message symbols per frame and emits n symbols: the k message symbols unchanged, then n-k parity symbols.
- Upstream sees o_in_ready low while parity is emitted. Output has no backpressure.

Parameters:
- word_length, 8, symbol width in bits; field GF(2^8), primitive polynomial 0x11D.
- n, 15, codeword length in symbols; shortened code, n <= 2^word_length - 1.
- k, 11, message length in symbols; 2 <= k < n.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start_codeword  in  1  first message symbol of a frame.
- i_end_codeword  in  1  last message symbol of a frame.
- i_valid  in  1  i_symbol valid; transfer occurs when i_valid && o_in_ready.
- i_symbol  in  word_length  message symbol.
- o_start_codeword  out  1  first symbol of the output codeword.
- o_end_codeword  out  1  last symbol of the output codeword, or of an aborted frame.
- o_error  out  1  framing error, one-cycle pulse.
- o_in_ready  out  1  encoder can accept a symbol this cycle.
- o_valid  out  1  o_symbol valid.
- o_symbol  out  word_length  codeword symbol.

Behaviour:
- Reset: all outputs are registered and reset to 0, except o_in_ready, which is 1. State is IDLE, the symbol counter is 0, and all parity registers p[0..n-k-1] are 0. A reset mid-frame discards the frame with no end marker emitted.
- Generator polynomial: g(x) = prod_{i=0}^{n-k-1} (x + alpha^i), with alpha = 0x02. Coefficients g[0..n-k-1] are elaboration-time constants; the default is g = x^4 + 0F x^3 + 36 x^2 + 78 x + 40.
- LFSR update on each accepted message symbol s:
  - f = s ^ p[n-k-1], where p[n-k-1] is taken as 0 for the first symbol of a frame.
  - p[0] <= f*g[0]; p[j] <= p[j-1] ^ f*g[j].
  - For the first symbol, every p[j-1] term is taken as 0. All multiplies are GF multiplies, all sums XOR.
- FSM, IDLE:
  - o_in_ready = 1.
  - i_valid && i_start_codeword: accept the symbol, seed the LFSR, counter = 1, go to MSG. The next cycle shows o_valid = 1, o_symbol = s, o_start_codeword = 1.
  - i_valid without start: drop the symbol, pulse o_error next cycle, o_valid stays 0.
- FSM, MSG:
  - o_in_ready = 1. Each accepted symbol is echoed on the output with 1-cycle latency and the counter increments.
  - Counter == k-1 with i_end_codeword: normal last symbol; go to PARITY.
  - Counter == k-1 without i_end_codeword: treated as the end anyway; o_error pulses alongside that output symbol; go to PARITY.
  - i_end_codeword with counter < k-1: abort. The symbol is echoed with o_end_codeword = 1 and o_error = 1, the LFSR is cleared, go to IDLE, no parity is emitted.
  - i_start_codeword while in MSG: o_error pulses alongside that symbol; it restarts the frame as a new first symbol with o_start_codeword = 1, the LFSR is reseeded, counter = 1.
  - Start and end together in IDLE or MSG (a 1-symbol frame): treated as start followed by an early-end abort. The output shows start, end and error together.
- FSM, PARITY:
  - o_in_ready = 0. Lasts exactly n-k cycles.
  - Each cycle: o_symbol <= p[n-k-1], then shift p[j] <= p[j-1], p[0] <= 0.
  - o_end_codeword is set on the last parity symbol, then go to IDLE.
- Timing: if the last message symbol is accepted at cycle t, it is output at t+1 and parity at t+2..t+n-k+1. o_in_ready is low during t+1..t+n-k.
- Back-to-back frames: o_in_ready returns to 1 at t+n-k+1, so back-to-back frames produce a gap-free output stream.
- o_valid = 0 on idle cycles; o_symbol then holds its last value.
- No input is accepted while o_in_ready = 0, regardless of i_valid.

Test Plan:
- Zero message: 11 symbols of 0x00, start on the first, end on the last -> 15 outputs of 0x00; o_start on output 1, o_end on output 15; o_in_ready low for 4 cycles.
- Unit message: 10 x 0x00 then 0x01 with end -> outputs 0x00 x10, 0x01, then parity 0F 36 78 40; o_error never asserted.
- Back-to-back: zero frame then unit frame with i_valid held high -> 30 contiguous o_valid cycles. The second frame's o_start directly follows the first frame's o_end, and no input is accepted while ready is low.
- Early end: start, 5 symbols, end on the 6th -> the 6th output carries o_end = 1 and o_error = 1, no parity follows, and o_in_ready stays 1.
- Framing errors:
  - Symbol with i_valid but no start in IDLE -> no o_valid, o_error pulses one cycle.
  - 11th symbol without end -> o_error pulses with that output symbol, and 4 parity symbols still follow.
- Async reset asserted on the 3rd parity cycle -> all outputs 0 immediately and o_in_ready = 1. A fresh zero frame after release encodes correctly.
